// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_sequencer: single-outstanding instruction fetch and PC control.    |
// | Optional feature macro: FETCH_SEQ_MISALIGN_TRAP_EN (misaligned redirect  |
// | traps to TRAP_VECTOR and pulses misalign_exc).                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        pll_1_200MHz,
  input  logic        pll_1_locked_synced,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        dec_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic [31:0] pc,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic [31:0] r_instr_data, w_instr_data_nxt;
  logic [31:0] r_instr_pc, w_instr_pc_nxt;
  logic        r_instr_valid, w_instr_valid_nxt;
  logic        r_kill, w_kill_nxt;
  logic        w_redirect;
  logic        w_misalign;
  logic [31:0] w_redirect_pc;

  // Redirects are ignored while IDLE so the first fetch always uses RESET_VECTOR.
  assign w_redirect = redirect_valid && (r_state != ST_IDLE);

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  logic r_misalign_exc;

  assign w_misalign    = (redirect_target[1:0] != 2'b00);
  assign w_redirect_pc = w_misalign ? TRAP_VECTOR : redirect_target;
  assign misalign_exc  = r_misalign_exc;

  always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
    if (!pll_1_locked_synced) begin
      r_misalign_exc <= 1'b0;
    end else begin
      r_misalign_exc <= w_redirect && w_misalign;
    end
  end
`else
  logic w_unused;

  assign w_misalign    = 1'b0;
  assign w_redirect_pc = {redirect_target[31:2], 2'b00};
  assign misalign_exc  = 1'b0;
  assign w_unused      = ^{TRAP_VECTOR, redirect_target[1:0], w_misalign};
`endif

  always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
    if (!pll_1_locked_synced) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
    if (!pll_1_locked_synced) begin
      r_pc          <= RESET_VECTOR;
      r_req_pc      <= 32'h0;
      r_instr_data  <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
      r_kill        <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_req_pc      <= w_req_pc_nxt;
      r_instr_data  <= w_instr_data_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_kill        <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_req_pc_nxt      = r_req_pc;
    w_instr_data_nxt  = r_instr_data;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_kill_nxt        = r_kill;

    if (w_redirect) begin
      w_pc_nxt          = w_redirect_pc;
      w_instr_valid_nxt = 1'b0;
      case (r_state)
        ST_REQ: begin
          // A grant racing the redirect leaves a stale response to discard.
          w_state_nxt = imem_gnt ? ST_WAIT : ST_REQ;
          w_kill_nxt  = imem_gnt;
        end
        ST_WAIT: begin
          w_state_nxt = imem_rvalid ? ST_REQ : ST_WAIT;
          w_kill_nxt  = !imem_rvalid;
        end
        default: begin
          w_state_nxt = ST_REQ;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (imem_gnt) begin
            w_req_pc_nxt = r_pc;
            w_pc_nxt     = r_pc + 32'd4;
            w_state_nxt  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = ST_REQ;
            end else begin
              w_instr_data_nxt  = imem_rdata;
              w_instr_pc_nxt    = r_req_pc;
              w_instr_valid_nxt = 1'b1;
              w_state_nxt       = ST_HOLD;
            end
          end
        end
        default: begin
          if (dec_ready) begin
            w_instr_valid_nxt = 1'b0;
            w_state_nxt       = ST_REQ;
          end
        end
      endcase
    end
  end

  assign imem_req    = (r_state == ST_REQ);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_data  = r_instr_data;
  assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Directed self-checking bench for fetch_sequencer; a second instance starts
// at 0xFFFF_FFF8 to exercise PC wrap-around.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_ready;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        iv0, iv1;
  logic [31:0] idata0, idata1;
  logic [31:0] ipc0, ipc1;
  logic [31:0] pc0, pc1;
  logic        mis0, mis1;

  int n_tests;
  int n_fail;

  fetch_sequencer u_dut0 (
    .pll_1_200MHz        (clk),
    .pll_1_locked_synced (rst_n),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .dec_ready           (dec_ready),
    .imem_req            (req0),
    .imem_addr           (addr0),
    .imem_gnt            (imem_gnt),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .instr_valid         (iv0),
    .instr_data          (idata0),
    .instr_pc            (ipc0),
    .pc                  (pc0),
    .misalign_exc        (mis0)
  );

  fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut1 (
    .pll_1_200MHz        (clk),
    .pll_1_locked_synced (rst_n),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .dec_ready           (dec_ready),
    .imem_req            (req1),
    .imem_addr           (addr1),
    .imem_gnt            (imem_gnt),
    .imem_rvalid         (imem_rvalid),
    .imem_rdata          (imem_rdata),
    .instr_valid         (iv1),
    .instr_data          (idata1),
    .instr_pc            (ipc1),
    .pc                  (pc1),
    .misalign_exc        (mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full fetch from REQ to decode hand-off; leaves the DUT back in REQ.
  task automatic fetch(input logic [31:0] a, input logic [31:0] a1, input bit chk1,
                       input logic [31:0] data, input int hold_cycles);
    check("req_on", {31'b0, req0}, 32'd1);
    check("req_addr", addr0, a);
    check("no_valid_in_req", {31'b0, iv0}, 32'd0);
    if (chk1) check("wrap_addr", addr1, a1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("req_off_wait", {31'b0, req0}, 32'd0);
    check("no_valid_in_wait", {31'b0, iv0}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    check("valid_after_rvalid", {31'b0, iv0}, 32'd1);
    check("instr_pc", ipc0, a);
    check("instr_data", idata0, data);
    if (chk1) check("wrap_instr_pc", ipc1, a1);
    dec_ready = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      check("hold_valid", {31'b0, iv0}, 32'd1);
      check("hold_data", idata0, data);
      check("hold_pc", ipc0, a);
      check("hold_no_req", {31'b0, req0}, 32'd0);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    dec_ready       = 1'b0;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;

    repeat (2) tick();
    check("rst_req", {31'b0, req0}, 32'd0);
    check("rst_valid", {31'b0, iv0}, 32'd0);
    check("rst_data", idata0, 32'h0);
    check("rst_ipc", ipc0, 32'h0);
    check("rst_pc", pc0, 32'h0);
    check("rst_mis", {31'b0, mis0}, 32'd0);
    check("rst_pc_wrap", pc1, 32'hFFFF_FFF8);

    rst_n = 1'b1;
    check("idle_no_req", {31'b0, req0}, 32'd0);
    tick();

    // Sequential fetch, wrap on the second instance, then a 5-cycle stall.
    fetch(32'h0, 32'hFFFF_FFF8, 1'b1, 32'hA000_0000, 0);
    fetch(32'h4, 32'hFFFF_FFFC, 1'b1, 32'hA000_0004, 0);
    fetch(32'h8, 32'h0000_0000, 1'b1, 32'hA000_0008, 5);
    fetch(32'hC, 32'h0000_0004, 1'b1, 32'hA000_000C, 0);

    // Redirect while waiting on 0x10: its data must be discarded.
    check("req_0x10", addr0, 32'h10);
    imem_gnt = 1'b1;
    tick();
    imem_gnt        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("kill_wait_no_req", {31'b0, req0}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0010;
    tick();
    imem_rvalid = 1'b0;
    check("killed_no_valid", {31'b0, iv0}, 32'd0);
    fetch(32'h200, 32'h200, 1'b1, 32'hA000_0200, 0);

    // Redirect in the same cycle as grant.
    imem_gnt        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    check("gnt_redir_no_req", {31'b0, req0}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0204;
    tick();
    imem_rvalid = 1'b0;
    check("gnt_redir_no_valid", {31'b0, iv0}, 32'd0);
    fetch(32'h300, 32'h300, 1'b1, 32'hA000_0300, 0);

    // Redirect in the same cycle as rvalid.
    imem_gnt = 1'b1;
    tick();
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b1;
    imem_rdata      = 32'hBAD0_0304;
    redirect_valid  = 1'b1;
    redirect_target = 32'h400;
    tick();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    check("rv_redir_no_valid", {31'b0, iv0}, 32'd0);
    fetch(32'h400, 32'h400, 1'b1, 32'hA000_0400, 0);

    // Redirect while holding an instruction drops it.
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA000_0404;
    tick();
    imem_rvalid = 1'b0;
    check("hold_before_redir", {31'b0, iv0}, 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h500;
    tick();
    redirect_valid = 1'b0;
    check("hold_redir_dropped", {31'b0, iv0}, 32'd0);

    // Stray rvalid outside WAIT is ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0500;
    tick();
    imem_rvalid = 1'b0;
    check("stray_rv_no_valid", {31'b0, iv0}, 32'd0);
    check("stray_rv_addr", addr0, 32'h500);

    // Misaligned redirect.
    redirect_valid  = 1'b1;
    redirect_target = 32'h202;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    check("mis_pulse", {31'b0, mis0}, 32'd1);
    check("mis_addr", addr0, 32'h100);
`else
    check("mis_pulse", {31'b0, mis0}, 32'd0);
    check("mis_addr", addr0, 32'h200);
`endif
    tick();
    check("mis_one_cycle", {31'b0, mis0}, 32'd0);

    // Same target on consecutive cycles yields a single fetch.
    redirect_valid  = 1'b1;
    redirect_target = 32'h600;
    tick();
    tick();
    redirect_valid = 1'b0;
    fetch(32'h600, 32'h600, 1'b1, 32'hA000_0600, 0);
    check("after_600", addr0, 32'h604);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter. Decides the next fetch address, issues instruction-memory requests, and delivers fetched instructions to decode.
- Handles sequential advance (PC+4), branch/jump redirects, decode back-pressure and discard of in-flight fetches.
- Sits between the PC register and instruction memory.
- Only one outstanding fetch at a time.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, target used on misaligned redirect (optional feature only).

Ports:
- pll_1_200MHz  input  1  sole clock, rising edge.
- pll_1_locked_synced  input  1  reset; one clock; reset is asynchronous and active-low.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- dec_ready  input  1  decode can accept an instruction.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; equals pc.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instruction presented to decode.
- instr_data  output  32  instruction word.
- instr_pc  output  32  address of instr_data.
- pc  output  32  current fetch PC; feeds the Program_Counter input.
- misalign_exc  output  1  one-cycle pulse on a misaligned redirect (feature only, else tied 0).

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_VECTOR; state=IDLE.
  - imem_req=0, instr_valid=0, instr_data=0, instr_pc=0, misalign_exc=0, kill=0.
- States:
  - IDLE: single cycle after reset release -> REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt: latch req_pc=pc, pc<=pc+4 (wraps mod 2^32, 32'hFFFF_FFFC+4=0), -> WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - kill=1: drop the data, clear kill, -> REQ.
    - kill=0: instr_data<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, -> HOLD.
  - HOLD: instr_valid=1; instr_data and instr_pc held stable. On dec_ready: instr_valid<=0 and -> REQ. Next request is issued the cycle after dec_ready.
- Latency: gnt to instr_valid is 1 cycle after rvalid (registered). With gnt and rvalid both immediate, throughput is one instruction per 3 cycles.
- Redirect (highest priority, any state except IDLE):
  - pc<=redirect_target; instr_valid<=0 next cycle.
  - REQ: the current request is withdrawn next cycle. If gnt arrives the same cycle as redirect, set kill=1 and -> WAIT.
  - WAIT: kill<=1; stay in WAIT. If rvalid arrives the same cycle as redirect, drop the data; -> REQ, kill stays 0.
  - HOLD: drop the held instruction; -> REQ.
- Redirect with the same target on consecutive cycles: the last one wins; no duplicate fetch.
- Reset mid-WAIT: state and kill cleared. Any late rvalid arriving in IDLE/REQ is ignored.
- redirect_target bits [1:0] are forced to 0 when the feature is disabled.
- imem_rvalid outside WAIT: ignored.

Optional Feature:
- Macro: FETCH_SEQ_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_target[1:0]!=0 sets pc<=TRAP_VECTOR instead of the target, and pulses misalign_exc=1 for one cycle in the cycle after the redirect. All kill/discard rules are unchanged.
- Undefined: no check; target[1:0] masked to 0; misalign_exc tied 0 and the TRAP_VECTOR parameter is unused.

Test Plan:
- Reset release, gnt/rvalid each 1 cycle after request, dec_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; instr_valid asserts 1 cycle after each rvalid.
- dec_ready=0 for 5 cycles while instr_valid=1 -> instr_data/instr_pc stable, imem_req=0 throughout; request for pc+4 issued the cycle after dec_ready rises.
- Redirect to 0x200 while in WAIT for addr 0x10 -> rdata for 0x10 discarded (instr_valid stays 0); next imem_addr=0x200.
- Redirect same cycle as rvalid, and redirect same cycle as gnt -> no stale instruction delivered; next instruction delivered has instr_pc=target.
- Start at RESET_VECTOR=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_SEQ_MISALIGN_TRAP_EN: redirect to 0x202 -> misalign_exc pulses once, next imem_addr=0x100. Without the macro -> next imem_addr=0x200, misalign_exc=0.
